// File: rtl/multicycle_maindec_if.sv
// Control bundle between the multicycle main decoder (master) and the datapath (slave).
// The decoder reads the opcode and zero flag, and drives the mux selects and write strobes.
interface multicycle_maindec_if;
    logic [5:0] op;
    logic       zero;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       pcen;
    logic [3:0] state;

    modport master (
        input  op, zero,
        output iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, aluop, pcsrc, pcen, state
    );

    modport slave (
        output op, zero,
        input  iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, aluop, pcsrc, pcen, state
    );
endinterface

// File: rtl/multicycle_maindec.sv
// Moore control FSM for a multicycle MIPS datapath (lw, sw, R-type, beq, addi, j).
// Control outputs are registered alongside the state; only pcen looks at the zero flag.
module multicycle_maindec #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_ADDI  = 6'b001000,
    parameter logic [5:0] OP_J     = 6'b000010
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_maindec_if.master bus
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       pcwrite;
        logic       branch;
    } ctrl_t;

    // Encodings 12-15 fall through to all-zero controls.
    function automatic ctrl_t f_ctrl(input logic [3:0] s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.irwrite = 1'b1;
                c.pcwrite = 1'b1;
                c.alusrcb = 2'b01;
            end
            DECODE:  c.alusrcb = 2'b11;
            MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            MEMRD:   c.iord = 1'b1;
            MEMWB: begin
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
            end
            MEMWR: begin
                c.iord     = 1'b1;
                c.memwrite = 1'b1;
            end
            RTYPEEX: begin
                c.alusrca = 1'b1;
                c.aluop   = 2'b10;
            end
            RTYPEWB: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
            end
            BEQEX: begin
                c.alusrca = 1'b1;
                c.aluop   = 2'b01;
                c.pcsrc   = 2'b01;
                c.branch  = 1'b1;
            end
            ADDIEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            ADDIWB:  c.regwrite = 1'b1;
            JEX: begin
                c.pcsrc   = 2'b10;
                c.pcwrite = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    logic [3:0] r_state;
    ctrl_t      r_ctrl;
    logic [3:0] w_next;
    ctrl_t      w_ctrl;

    always_comb begin
        w_next = FETCH;
        case (r_state)
            FETCH:  w_next = DECODE;
            DECODE: begin
                if (bus.op == OP_LW || bus.op == OP_SW) w_next = MEMADR;
                else if (bus.op == OP_RTYPE)            w_next = RTYPEEX;
                else if (bus.op == OP_BEQ)              w_next = BEQEX;
                else if (bus.op == OP_ADDI)             w_next = ADDIEX;
                else if (bus.op == OP_J)                w_next = JEX;
                else                                    w_next = FETCH;
            end
            MEMADR:  w_next = (bus.op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   w_next = MEMWB;
            RTYPEEX: w_next = RTYPEWB;
            ADDIEX:  w_next = ADDIWB;
            default: w_next = FETCH;
        endcase
    end

    // Outputs are precomputed from the next state so they line up with r_state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FETCH;
            r_ctrl  <= f_ctrl(FETCH);
        end else begin
            r_state <= w_next;
            r_ctrl  <= f_ctrl(w_next);
        end
    end

    assign w_ctrl = reset ? '0 : r_ctrl;

    assign bus.iord     = w_ctrl.iord;
    assign bus.memwrite = w_ctrl.memwrite;
    assign bus.irwrite  = w_ctrl.irwrite;
    assign bus.regdst   = w_ctrl.regdst;
    assign bus.memtoreg = w_ctrl.memtoreg;
    assign bus.regwrite = w_ctrl.regwrite;
    assign bus.alusrca  = w_ctrl.alusrca;
    assign bus.alusrcb  = w_ctrl.alusrcb;
    assign bus.aluop    = w_ctrl.aluop;
    assign bus.pcsrc    = w_ctrl.pcsrc;
    assign bus.pcen     = w_ctrl.pcwrite | (w_ctrl.branch & bus.zero);
    assign bus.state    = r_state;

endmodule
